// File: rtl/nonbin_class_seq_ctrl_if.sv
// Bundle between the training FSM and the class-HV segment sequencer.
// The training side (master) drives the pass request and the inference select.
// The sequencer (slave) drives the class register controls and pass status.
interface nonbin_class_seq_ctrl_if;
    logic       start;
    logic       op_sub;
    logic       abort;
    logic [1:0] infer_sel;
    logic [1:0] class_ctr;
    logic [1:0] nonbin_ctr;
    logic       adjusting_nonbin_class_hvs;
    logic       add_en;
    logic       add_sub;
    logic       busy;
    logic       done;

    modport master (
        output start, op_sub, abort, infer_sel,
        input  class_ctr, nonbin_ctr, adjusting_nonbin_class_hvs,
               add_en, add_sub, busy, done
    );

    modport slave (
        input  start, op_sub, abort, infer_sel,
        output class_ctr, nonbin_ctr, adjusting_nonbin_class_hvs,
               add_en, add_sub, busy, done
    );
endinterface

// File: rtl/nonbin_class_seq_ctrl.sv
// Read-modify-write sequencer for the segmented nonbinary class-HV register.
// A pass reads segments 0..3 in order, follows each one through the external
// add/subtract datapath with a {valid, index} delay line, and writes it back
// exactly ADD_LATENCY cycles after its read. While idle, the inference select
// is forwarded to the register read select.
module nonbin_class_seq_ctrl #(
    parameter int SEQ_CYCLE_COUNT = 4,
    parameter int ADD_LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   nrst,
    nonbin_class_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0]             LAST_SEG  = 2'(SEQ_CYCLE_COUNT - 1);
    // Marks the output stage of the delay line; every other stage is "in flight".
    localparam logic [ADD_LATENCY-1:0] LAST_MASK = ADD_LATENCY'(1) << (ADD_LATENCY - 1);

    state_t                 r_state;
    logic [1:0]             r_classCtr;
    logic                   r_addEn;
    logic                   r_addSub;
    logic                   r_done;
    logic [ADD_LATENCY-1:0] r_pipeValid;
    logic [1:0]             r_pipeIdx [ADD_LATENCY];

    state_t                 w_nextState;
    logic [1:0]             w_classCtrNext;
    logic                   w_addEnNext;
    logic                   w_addSubNext;
    logic                   w_doneNext;
    logic                   w_flush;
    logic                   w_lastWrite;

    // The write leaving the output stage now is the final one when nothing else is in flight
    assign w_lastWrite = ((r_pipeValid & ~LAST_MASK) == '0) && !r_addEn;

    // State register and registered control outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_classCtr <= 2'd0;
            r_addEn    <= 1'b0;
            r_addSub   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_classCtr <= w_classCtrNext;
            r_addEn    <= w_addEnNext;
            r_addSub   <= w_addSubNext;
            r_done     <= w_doneNext;
        end
    end

    // Next state and next values of the read-side controls
    always_comb begin
        w_nextState    = r_state;
        w_classCtrNext = r_classCtr;
        w_addEnNext    = 1'b0;
        w_addSubNext   = r_addSub;
        w_doneNext     = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            IDLE: begin
                w_classCtrNext = bus.infer_sel;
                if (bus.start && !bus.abort) begin
                    w_nextState    = ISSUE;
                    w_classCtrNext = 2'd0;
                    w_addEnNext    = 1'b1;
                    w_addSubNext   = bus.op_sub;
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    w_nextState    = IDLE;
                    w_flush        = 1'b1;
                    w_classCtrNext = bus.infer_sel;
                end else if (r_classCtr == LAST_SEG) begin
                    w_nextState = DRAIN;
                end else begin
                    w_classCtrNext = r_classCtr + 2'd1;
                    w_addEnNext    = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    w_nextState    = IDLE;
                    w_flush        = 1'b1;
                    w_classCtrNext = bus.infer_sel;
                end else if (w_lastWrite) begin
                    w_nextState = IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_flush     = 1'b1;
            end
        endcase
    end

    // Adder-latency delay line; indices only move with a valid entry so the write select holds between passes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pipeValid <= '0;
            for (int i = 0; i < ADD_LATENCY; i++) begin
                r_pipeIdx[i] <= 2'd0;
            end
        end else if (w_flush) begin
            r_pipeValid <= '0;
        end else begin
            r_pipeValid[0] <= r_addEn;
            if (r_addEn) begin
                r_pipeIdx[0] <= r_classCtr;
            end
            for (int i = 1; i < ADD_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                if (r_pipeValid[i-1]) begin
                    r_pipeIdx[i] <= r_pipeIdx[i-1];
                end
            end
        end
    end

    assign bus.class_ctr                  = r_classCtr;
    assign bus.add_en                     = r_addEn;
    assign bus.add_sub                    = r_addSub;
    assign bus.done                       = r_done;
    assign bus.busy                       = (r_state != IDLE);
    assign bus.adjusting_nonbin_class_hvs = r_pipeValid[ADD_LATENCY-1];
    assign bus.nonbin_ctr                 = r_pipeIdx[ADD_LATENCY-1];

endmodule
